pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_timebase.sv | 41 ++++
 rtl/pwm_peripheral.sv | 73 +++++++
 tb/tb_pwm_peripheral.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// PWM peripheral shared types and constants.
// Imported by the timebase and the peripheral top.
package pwm_pkg;

    localparam int CLK_DIV_DEF = 13;
    localparam int PWM_BITS    = 8;
    localparam int NUM_CH      = 16;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    typedef logic [PWM_BITS-1:0] pwm_cnt_t;
    typedef logic [NUM_CH-1:0]   pwm_ch_t;

    // 0xFF is promoted to 100 % so the top code gives no low step.
    function automatic logic pwm_level(
        input pwm_cnt_t cnt,
        input pwm_cnt_t duty
    );
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Clock prescaler plus 8-bit PWM period counter.
// Tick marks the last clk of each counter step; wrap marks 255 -> 0.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    output pwm_cnt_t o_count,
    output logic     o_tick,
    output logic     o_wrap
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_pre;
    pwm_cnt_t    r_count;
    logic        w_tick;
    logic        w_wrap;

    assign w_tick = (r_pre == DIV_LAST);
    assign w_wrap = w_tick && (r_count == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign o_count = r_count;
    assign o_tick  = w_tick;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral with shared, period-shadowed duty.
// All outputs are registered; enables take effect one clk later.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_div
        $error("pwm_peripheral: CLK_DIV must be within 1..65535");
    end

    pwm_cnt_t w_count;
    logic     w_tick;
    logic     w_wrap;
    logic     w_level;
    pwm_ch_t  w_en_out;
    pwm_ch_t  w_en_pwm;
    pwm_ch_t  w_next;

    pwm_cnt_t r_shadow;
    pwm_ch_t  r_out;
    logic     r_wrap_q;
    logic     r_period_start;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_count (w_count),
        .o_tick  (w_tick),
        .o_wrap  (w_wrap)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_level  = pwm_level(w_count, r_shadow);
    assign w_next   = w_en_out & (~w_en_pwm | {NUM_CH{w_level}});

    // period_start trails the wrap by one clk to line up with r_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow       <= '0;
            r_out          <= '0;
            r_wrap_q       <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick && w_wrap) begin
                r_shadow <= pwm_duty_cycle;
            end
            r_wrap_q       <= w_tick && w_wrap;
            r_period_start <= r_wrap_q;
            r_out          <= w_next;
        end
    end

    assign out_7_0      = r_out[7:0];
    assign out_15_8     = r_out[15:8];
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (CLK_DIV=13 and CLK_DIV=1).
// A cycle-count reference model tracks the CLK_DIV=13 instance.
module tb_pwm_peripheral;

    localparam int D   = 13;
    localparam int PER = 256 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [7:0] o13_lo, o13_hi, o1_lo, o1_hi;
    logic       ps13, ps1;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(D)) dut13 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out_7_0         (o13_lo),
        .out_15_8        (o13_hi),
        .period_start    (ps13)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out_7_0         (o1_lo),
        .out_15_8        (o1_hi),
        .period_start    (ps1)
    );

    wire [15:0] out13  = {o13_hi, o13_lo};
    wire [15:0] out1   = {o1_hi, o1_lo};
    wire [15:0] en_out = {eo_hi, eo_lo};
    wire [15:0] en_pwm = {ep_hi, ep_lo};

    // Reference model: state is just the number of clk edges since reset.
    int         m_n;
    logic [7:0] m_shadow;
    logic [15:0] m_out;
    logic       m_ps;
    int         m_cnt;
    bit         m_lvl;

    always_comb begin
        m_cnt = (m_n / D) % 256;
        m_lvl = (m_shadow == 8'hFF) || (m_cnt < int'(m_shadow));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= 0;
            m_shadow <= 8'h00;
            m_out    <= 16'h0;
            m_ps     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (!en_out[i])      m_out[i] <= 1'b0;
                else if (!en_pwm[i]) m_out[i] <= 1'b1;
                else                 m_out[i] <= m_lvl;
            end
            m_ps <= (m_n > 0) && (m_n % PER == 0);
            if ((m_n + 1) % PER == 0) m_shadow <= duty;
            m_n <= m_n + 1;
        end
    end

    task automatic set_en(input logic [15:0] o, input logic [15:0] p);
        {eo_hi, eo_lo} = o;
        {ep_hi, ep_lo} = p;
    endtask

    task automatic wait_ps(input bit d1, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < budget && !ok) begin
            if ((d1 ? ps1 : ps13) === 1'b1) ok = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic measure(input bit d1, input int n, output int hi,
                           output int rises, output int others,
                           output int psn, output bit first);
        bit b, prev;
        hi = 0; rises = 0; others = 0; psn = 0; first = 0; prev = 0;
        for (int k = 0; k < n; k++) begin
            b = d1 ? o1_lo[0] : o13_lo[0];
            if (k == 0) first = b;
            else if (b && !prev) rises++;
            if (b) hi++;
            if ((d1 ? out1[15:1] : out13[15:1]) != 15'h0) others++;
            if (k > 0 && (d1 ? ps1 : ps13)) psn++;
            prev = b;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_en(16'hFFFF, 16'h0000);
        duty = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if (out13 !== 16'h0) begin
            errors++; $display("FAIL reset_out13 got %h want 0000", out13);
        end
        checks++;
        if (ps13 !== 1'b0) begin
            errors++; $display("FAIL reset_ps13 got %b want 0", ps13);
        end
        checks++;
        if (out1 !== 16'h0) begin
            errors++; $display("FAIL reset_out1 got %h want 0000", out1);
        end
        checks++;
        if (ps1 !== 1'b0) begin
            errors++; $display("FAIL reset_ps1 got %b want 0", ps1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_static();
        @(negedge clk);
        set_en(16'h0000, 16'h0000);
        @(negedge clk);
        checks++;
        if (out13 !== 16'h0) begin
            errors++; $display("FAIL static_off got %h want 0000", out13);
        end
        set_en(16'hFFFF, 16'h0000);
        #1;
        checks++;
        if (out13 !== 16'h0) begin
            errors++; $display("FAIL static_comb got %h want 0000", out13);
        end
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (out13 !== 16'hFFFF || out1 !== 16'hFFFF) begin
                errors++;
                $display("FAIL static_on k=%0d got %h/%h want ffff", k, out13, out1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 7000; k++) begin
            @(negedge clk);
            checks++;
            if (out13 !== m_out) begin
                errors++;
                $display("FAIL rand_out k=%0d got %h want %h", k, out13, m_out);
            end
            checks++;
            if (ps13 !== m_ps) begin
                errors++;
                $display("FAIL rand_ps k=%0d got %b want %b", k, ps13, m_ps);
            end
            if ($urandom_range(99) < 2) duty = 8'($urandom);
            if ($urandom_range(99) < 1) set_en(16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_half();
        bit ok, first;
        int hi, rises, others, psn;
        set_en(16'h0001, 16'h0001);
        duty = 8'h80;
        repeat (2) @(negedge clk);
        wait_ps(0, PER + 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL half_wait got timeout want period_start");
        end
        measure(0, PER, hi, rises, others, psn, first);
        checks++;
        if (hi != 1664 || !first || rises != 0) begin
            errors++;
            $display("FAIL half_high got %0d first=%b rises=%0d want 1664 1 0",
                     hi, first, rises);
        end
        checks++;
        if (others != 0 || psn != 0) begin
            errors++;
            $display("FAIL half_other got %0d ps=%0d want 0 0", others, psn);
        end
        checks++;
        if (ps13 !== 1'b1) begin
            errors++; $display("FAIL half_period got %b want 1", ps13);
        end
    endtask

    task automatic test_extremes();
        bit ok, first;
        int hi, rises, others, psn;
        logic [7:0] dv [2];
        dv[0] = 8'h00;
        dv[1] = 8'hFF;
        for (int j = 0; j < 2; j++) begin
            duty = dv[j];
            repeat (2) @(negedge clk);
            wait_ps(0, PER + 100, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL ext_wait got timeout want period_start");
            end
            measure(0, 3 * PER, hi, rises, others, psn, first);
            checks++;
            if (hi != (j == 0 ? 0 : 3 * PER) || rises != 0) begin
                errors++;
                $display("FAIL ext_high duty=%h got %0d rises=%0d want %0d 0",
                         dv[j], hi, rises, (j == 0 ? 0 : 3 * PER));
            end
            checks++;
            if (psn != 2) begin
                errors++; $display("FAIL ext_ps got %0d want 2", psn);
            end
        end
    endtask

    task automatic test_glitch();
        bit ok, first;
        int hi, hi2, rises, rises2, others, psn;
        duty = 8'h40;
        repeat (2) @(negedge clk);
        wait_ps(0, PER + 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL glitch_wait got timeout want period_start");
        end
        measure(0, 1000, hi, rises, others, psn, first);
        duty = 8'hC0;
        measure(0, PER - 1000, hi2, rises2, others, psn, first);
        checks++;
        if (hi + hi2 != 832 || rises + rises2 != 0) begin
            errors++;
            $display("FAIL glitch_cur got %0d rises=%0d want 832 0",
                     hi + hi2, rises + rises2);
        end
        checks++;
        if (ps13 !== 1'b1) begin
            errors++; $display("FAIL glitch_ps got %b want 1", ps13);
        end
        measure(0, PER, hi, rises, others, psn, first);
        checks++;
        if (hi != 2496 || rises != 0 || !first) begin
            errors++;
            $display("FAIL glitch_next got %0d rises=%0d first=%b want 2496 0 1",
                     hi, rises, first);
        end
    endtask

    task automatic test_reset_mid();
        int found, pwm_hi;
        set_en(16'hFFFF, 16'h0000);
        duty = 8'hFF;
        repeat (700) @(negedge clk);
        checks++;
        if (out13 !== 16'hFFFF) begin
            errors++; $display("FAIL rmid_pre got %h want ffff", out13);
        end
        @(posedge clk);
        #20 rst_n = 1'b0;
        #1;
        checks++;
        if (out13 !== 16'h0 || ps13 !== 1'b0 || out1 !== 16'h0) begin
            errors++;
            $display("FAIL rmid_async got %h/%b/%h want 0000/0/0000",
                     out13, ps13, out1);
        end
        set_en(16'h0001, 16'h0001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        found  = 0;
        pwm_hi = 0;
        for (int k = 1; k <= PER + 60 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (ps13) found = k;
            else if (o13_lo[0]) pwm_hi++;
        end
        checks++;
        if (found != PER + 1) begin
            errors++; $display("FAIL rmid_first_ps got %0d want %0d", found, PER + 1);
        end
        checks++;
        if (pwm_hi != 0) begin
            errors++; $display("FAIL rmid_first_period got %0d want 0", pwm_hi);
        end
        @(negedge clk);
    endtask

    task automatic test_div1();
        bit ok, first;
        int hi, rises, others, psn;
        set_en(16'h0001, 16'h0001);
        duty = 8'h01;
        repeat (2) @(negedge clk);
        wait_ps(1, 300, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL div1_wait got timeout want period_start");
        end
        for (int j = 0; j < 2; j++) begin
            measure(1, 256, hi, rises, others, psn, first);
            checks++;
            if (hi != 1 || !first || rises != 0) begin
                errors++;
                $display("FAIL div1_high got %0d first=%b rises=%0d want 1 1 0",
                         hi, first, rises);
            end
            checks++;
            if (ps1 !== 1'b1 || psn != 0) begin
                errors++; $display("FAIL div1_ps got %b/%0d want 1/0", ps1, psn);
            end
        end
    endtask

    initial begin
        set_en(16'h0000, 16'h0000);
        duty = 8'h00;
        test_reset();
        test_static();
        test_random();
        test_half();
        test_extremes();
        test_glitch();
        test_reset_mid();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
